// File: rtl/sum_collector.sv
// Collects DW-bit sums over valid/ready and emits one record (total, count, overflow) per block of N samples.
// Optional min/max tracking is built only when SUM_COLLECTOR_MINMAX_EN is defined.
module sum_collector #(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int AW = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DW-1:0]            in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [AW-1:0]            out_sum_o,
  output logic [$clog2(N+1)-1:0]   out_count_o,
  output logic                     out_ovf_o,
  output logic [DW-1:0]            out_min_o,
  output logic [DW-1:0]            out_max_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i
);

  localparam int CW = $clog2(N+1);

  typedef enum logic {ACC, HOLD} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [AW-1:0]  outSum_q, outSum_d;
  logic [CW-1:0]  outCount_q, outCount_d;
  logic           outOvf_q, outOvf_d;

  logic           accept;
  logic           closeBlock;
  logic           carry;
  logic [AW-1:0]  accSum;
  logic [AW-1:0]  accNext;
  logic [CW-1:0]  countNext;
  logic           ovfNext;

  assign in_ready_o  = (state_q == ACC) && !rst_i;
  assign out_valid_o = (state_q == HOLD);
  assign out_sum_o   = outSum_q;
  assign out_count_o = outCount_q;
  assign out_ovf_o   = outOvf_q;

  // The block closes on the Nth accept, or on a flush that has at least one sample to report.
  always_comb begin
    accept              = in_ready_o && in_valid_i;
    {carry, accSum}     = {1'b0, acc_q} + {{(AW + 1 - DW){1'b0}}, in_data_i};
    accNext             = accept ? accSum : acc_q;
    countNext           = accept ? count_q + CW'(1) : count_q;
    ovfNext             = ovf_q | (accept & carry);
    closeBlock          = (state_q == ACC) &&
                          ((accept && (count_q == CW'(N - 1))) ||
                           (flush_i && ((count_q != '0) || accept)));
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    outSum_d   = outSum_q;
    outCount_d = outCount_q;
    outOvf_d   = outOvf_q;
    case (state_q)
      ACC: begin
        if (closeBlock) begin
          state_d    = HOLD;
          outSum_d   = accNext;
          outCount_d = countNext;
          outOvf_d   = ovfNext;
          acc_d      = '0;
          count_d    = '0;
          ovf_d      = 1'b0;
        end else begin
          acc_d   = accNext;
          count_d = countNext;
          ovf_d   = ovfNext;
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ACC;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      outSum_q   <= '0;
      outCount_q <= '0;
      outOvf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      outSum_q   <= outSum_d;
      outCount_q <= outCount_d;
      outOvf_q   <= outOvf_d;
    end
  end

`ifdef SUM_COLLECTOR_MINMAX_EN
  logic [DW-1:0] min_q, max_q, outMin_q, outMax_q;
  logic [DW-1:0] minNext, maxNext;

  // The first sample of a block seeds both extremes; later samples compare unsigned.
  always_comb begin
    minNext = min_q;
    maxNext = max_q;
    if (accept) begin
      if (count_q == '0) begin
        minNext = in_data_i;
        maxNext = in_data_i;
      end else begin
        minNext = (in_data_i < min_q) ? in_data_i : min_q;
        maxNext = (in_data_i > max_q) ? in_data_i : max_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q    <= '0;
      max_q    <= '0;
      outMin_q <= '0;
      outMax_q <= '0;
    end else if (closeBlock) begin
      outMin_q <= minNext;
      outMax_q <= maxNext;
      min_q    <= '0;
      max_q    <= '0;
    end else begin
      min_q <= minNext;
      max_q <= maxNext;
    end
  end

  assign out_min_o = outMin_q;
  assign out_max_o = outMax_q;
`else
  assign out_min_o = '0;
  assign out_max_o = '0;
`endif

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector: an AW=20 instance and an AW=17 instance share the same stimulus.
// Min/max expectations follow SUM_COLLECTOR_MINMAX_EN.
module tb_sum_collector;

`ifdef SUM_COLLECTOR_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inData;
  logic        inValid;
  logic        flush;
  logic        outReady;

  logic        inReadyA, ovfA, validA;
  logic [19:0] sumA;
  logic [2:0]  countA;
  logic [15:0] minA, maxA;

  logic        inReadyB, ovfB, validB;
  logic [16:0] sumB;
  logic [2:0]  countB;
  logic [15:0] minB, maxB;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_collector #(.DW(16), .N(4), .AW(20)) dutA (
    .clk_i(clk), .rst_i(rst), .in_data_i(inData), .in_valid_i(inValid),
    .in_ready_o(inReadyA), .flush_i(flush), .out_sum_o(sumA), .out_count_o(countA),
    .out_ovf_o(ovfA), .out_min_o(minA), .out_max_o(maxA), .out_valid_o(validA),
    .out_ready_i(outReady)
  );

  sum_collector #(.DW(16), .N(4), .AW(17)) dutB (
    .clk_i(clk), .rst_i(rst), .in_data_i(inData), .in_valid_i(inValid),
    .in_ready_o(inReadyB), .flush_i(flush), .out_sum_o(sumB), .out_count_o(countB),
    .out_ovf_o(ovfB), .out_min_o(minB), .out_max_o(maxB), .out_valid_o(validB),
    .out_ready_i(outReady)
  );

  task automatic send(input logic [15:0] d, input logic fl);
    inData = d; inValid = 1'b1; flush = fl;
    @(posedge clk); #1;
    inValid = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; inData = '0; flush = 1'b0; outReady = 1'b1;
    tick(); tick();
    checks++;
    if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=0", inReadyA); end
    checks++;
    if (validA !== 1'b0 || sumA !== 20'h0 || countA !== 3'd0 || ovfA !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_outputs valid=%0b sum=%0h count=%0d ovf=%0b exp all 0", validA, sumA, countA, ovfA);
    end
    rst = 1'b0; #1;
    checks++;
    if (inReadyA !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_ready got=%0b exp=1", inReadyA); end
  endtask

  task automatic test_basic();
    send(16'd1, 1'b0); send(16'd2, 1'b0); send(16'd3, 1'b0);
    checks++;
    if (validA !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid got=%0b exp=0", validA); end
    send(16'd4, 1'b0);
    checks++;
    if (validA !== 1'b1 || sumA !== 20'd10 || countA !== 3'd4 || ovfA !== 1'b0) begin
      failures++; $display("[TB] FAIL basic_record valid=%0b sum=%0d count=%0d ovf=%0b exp 1/10/4/0", validA, sumA, countA, ovfA);
    end
    checks++;
    if (minA !== (MM ? 16'd1 : 16'd0) || maxA !== (MM ? 16'd4 : 16'd0)) begin
      failures++; $display("[TB] FAIL basic_minmax min=%0d max=%0d exp %0d/%0d", minA, maxA, MM ? 1 : 0, MM ? 4 : 0);
    end
    tick();
    checks++;
    if (validA !== 1'b0 || inReadyA !== 1'b1) begin
      failures++; $display("[TB] FAIL basic_handoff valid=%0b ready=%0b exp 0/1", validA, inReadyA);
    end
  endtask

  task automatic test_hold();
    outReady = 1'b0;
    send(16'd10, 1'b0); send(16'd20, 1'b0); send(16'd30, 1'b0); send(16'd40, 1'b0);
    inValid = 1'b1; inData = 16'd99;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inReadyA !== 1'b0 || validA !== 1'b1 || sumA !== 20'd100 || countA !== 3'd4) begin
        failures++; $display("[TB] FAIL hold_stable cycle=%0d ready=%0b valid=%0b sum=%0d count=%0d exp 0/1/100/4", i, inReadyA, validA, sumA, countA);
      end
      tick();
    end
    inValid = 1'b0; outReady = 1'b1;
    tick();
    checks++;
    if (inReadyA !== 1'b1 || validA !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_release ready=%0b valid=%0b exp 1/0", inReadyA, validA);
    end
  endtask

  task automatic test_flush();
    send(16'hFFFF, 1'b0); send(16'h0001, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (validA !== 1'b1 || sumA !== 20'h10000 || countA !== 3'd2 || ovfA !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_record valid=%0b sum=%0h count=%0d ovf=%0b exp 1/10000/2/0", validA, sumA, countA, ovfA);
    end
    checks++;
    if (sumB !== 17'h10000 || ovfB !== 1'b0) begin
      failures++; $display("[TB] FAIL flush_aw17 sum=%0h ovf=%0b exp 10000/0", sumB, ovfB);
    end
    checks++;
    if (minA !== (MM ? 16'h0001 : 16'h0) || maxA !== (MM ? 16'hFFFF : 16'h0)) begin
      failures++; $display("[TB] FAIL flush_minmax min=%0h max=%0h", minA, maxA);
    end
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) send(16'hFFFF, 1'b0);
    checks++;
    if (validB !== 1'b1 || sumB !== 17'h1FFFC || ovfB !== 1'b1) begin
      failures++; $display("[TB] FAIL ovf_aw17 valid=%0b sum=%0h ovf=%0b exp 1/1fffc/1", validB, sumB, ovfB);
    end
    checks++;
    if (sumA !== 20'h3FFFC || ovfA !== 1'b0) begin
      failures++; $display("[TB] FAIL ovf_aw20 sum=%0h ovf=%0b exp 3fffc/0", sumA, ovfA);
    end
    tick();
    for (int i = 0; i < 4; i++) send(16'h0001, 1'b0);
    checks++;
    if (validB !== 1'b1 || sumB !== 17'd4 || ovfB !== 1'b0) begin
      failures++; $display("[TB] FAIL ovf_next_block valid=%0b sum=%0h ovf=%0b exp 1/4/0", validB, sumB, ovfB);
    end
    tick();
  endtask

  task automatic test_reset_midblock();
    send(16'd9, 1'b0); send(16'd9, 1'b0); send(16'd9, 1'b0);
    rst = 1'b1; #1;
    checks++;
    if (inReadyA !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready_comb got=%0b exp=0", inReadyA); end
    tick();
    rst = 1'b0;
    checks++;
    if (validA !== 1'b0 || sumA !== 20'd0) begin
      failures++; $display("[TB] FAIL rst_mid_outputs valid=%0b sum=%0d exp 0/0", validA, sumA);
    end
    send(16'd5, 1'b0); send(16'd5, 1'b0); send(16'd5, 1'b0);
    checks++;
    if (validA !== 1'b0) begin failures++; $display("[TB] FAIL rst_aborted_record valid=%0b exp=0", validA); end
    send(16'd5, 1'b0);
    checks++;
    if (validA !== 1'b1 || sumA !== 20'd20 || countA !== 3'd4) begin
      failures++; $display("[TB] FAIL rst_new_block valid=%0b sum=%0d count=%0d exp 1/20/4", validA, sumA, countA);
    end
    tick();
  endtask

  task automatic test_flush_edges();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++;
    if (validA !== 1'b0 || inReadyA !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_empty valid=%0b ready=%0b exp 0/1", validA, inReadyA);
    end
    send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b0); send(16'd7, 1'b1);
    checks++;
    if (validA !== 1'b1 || sumA !== 20'd28 || countA !== 3'd4) begin
      failures++; $display("[TB] FAIL flush_nth valid=%0b sum=%0d count=%0d exp 1/28/4", validA, sumA, countA);
    end
    tick();
    checks++;
    if (validA !== 1'b0) begin failures++; $display("[TB] FAIL flush_nth_single valid=%0b exp=0", validA); end
    tick();
    checks++;
    if (validA !== 1'b0 || inReadyA !== 1'b1) begin
      failures++; $display("[TB] FAIL flush_nth_idle valid=%0b ready=%0b exp 0/1", validA, inReadyA);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_flush();
    test_overflow();
    test_reset_midblock();
    test_flush_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
